// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C APB bridge: register offsets (word index
// paddr[4:2]), STATUS bit positions, the bridge FSM state type and a helper
// for the read-length field.
package i2c_pkg;

    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_RXDATA = 3'd2;
    localparam logic [2:0] REG_STATUS = 3'd3;
    localparam logic [2:0] REG_IRQ_EN = 3'd4;

    localparam int STAT_BUSY     = 0;
    localparam int STAT_NACK     = 1;
    localparam int STAT_DONE     = 2;
    localparam int STAT_RX_OVF   = 3;
    localparam int STAT_TX_FULL  = 4;
    localparam int STAT_TX_EMPTY = 5;
    localparam int STAT_RX_EMPTY = 6;
    localparam int STAT_RX_FULL  = 7;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WR_RUN = 3'd1,
        S_RD_RUN = 3'd2,
        S_GUARD  = 3'd3,
        S_DONE   = 3'd4
    } bridge_state_t;

    // A programmed read length of zero still reads one byte.
    function automatic logic [7:0] eff_rd_len(input logic [7:0] len);
        return (len == 8'd0) ? 8'd1 : len;
    endfunction

endpackage

// File: rtl/i2c_sync_fifo.sv
// Synchronous FIFO with flush. Push into a full FIFO is accepted only when
// a pop happens in the same cycle; pop from an empty FIFO is ignored.
// DEPTH must be a power of two so the pointers wrap naturally.
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CNT_FULL);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
    assign w_do_push = i_push & (~o_full | w_do_pop) & ~i_flush;

    // Pointer and occupancy bookkeeping; flush empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/i2c_apb_bridge.sv
// APB3 slave front end for the I2C master core. Buffers write/read bursts in
// TX/RX FIFOs and holds dv for the burst length so the core chains bytes.
// Optional feature macro: I2C_BRIDGE_IRQ_EN adds the IRQ_EN register and irq.
module i2c_apb_bridge
    import i2c_pkg::*;
#(
    parameter int FIFO_DEPTH   = 8,
    parameter int GUARD_CYCLES = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [4:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic        dv,
    output logic        write,
    output logic [6:0]  addr,
    output logic [7:0]  wdata,
    input  logic [7:0]  rdata,
    input  logic        i2c_ready,
    input  logic        i2c_error,
    input  logic        i2c_data_valid
`ifdef I2C_BRIDGE_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
    localparam logic [GW-1:0] GUARD_ONE  = GW'(1);

    bridge_state_t r_state, w_next_state;
    logic          r_dv, w_next_dv;
    logic          r_write, w_next_write;
    logic [6:0]    r_addr, w_next_addr;
    logic [7:0]    r_rd_remain, w_next_rd_remain;
    logic [GW-1:0] r_guard_cnt, w_next_guard_cnt;
    logic          r_ready_d, r_dval_d;
    logic          r_nack, r_done, r_rx_ovf;

    logic          w_access, w_wr, w_rd;
    logic [2:0]    w_off;
    logic          w_start_req, w_start_ok;
    logic          w_tx_push, w_tx_pop, w_tx_flush;
    logic          w_rx_push, w_rx_pop;
    logic          w_set_nack, w_set_done, w_set_ovf;
    logic          w_stat_wr;
    logic          w_ready_rise, w_dval_rise;
    logic          w_busy;
    logic [7:0]    w_status;
    logic [7:0]    w_tx_head, w_rx_head;
    logic          w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic [CW-1:0] w_tx_count, w_rx_count;
    logic          w_unused_bits;

    assign w_access     = psel & penable;
    assign w_wr         = w_access & pwrite;
    assign w_rd         = w_access & ~pwrite;
    assign w_off        = paddr[4:2];
    assign w_start_req  = w_wr & (w_off == REG_CTRL) & pwdata[0];
    assign w_start_ok   = w_start_req & (r_state == S_IDLE) & ~(pwdata[1] & w_tx_empty);
    assign w_tx_push    = w_wr & (w_off == REG_TXDATA) & ~w_tx_full;
    assign w_rx_pop     = w_rd & (w_off == REG_RXDATA) & ~w_rx_empty;
    assign w_stat_wr    = w_wr & (w_off == REG_STATUS);
    assign w_ready_rise = i2c_ready & ~r_ready_d;
    assign w_dval_rise  = i2c_data_valid & ~r_dval_d;
    assign w_busy       = (r_state != S_IDLE);
    assign w_status     = {w_rx_full, w_rx_empty, w_tx_empty, w_tx_full,
                           r_rx_ovf, r_done, r_nack, w_busy};
    assign w_unused_bits = ^{paddr[1:0], pwdata[31:24], pwdata[15], w_rx_count};

    assign pready = 1'b1;
    assign dv     = r_dv;
    assign write  = r_write;
    assign addr   = r_addr;
    assign wdata  = (r_state == S_WR_RUN) ? w_tx_head : 8'd0;

    i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst(rst),
        .i_push(w_tx_push), .i_data(pwdata[7:0]),
        .i_pop(w_tx_pop), .i_flush(w_tx_flush),
        .o_data(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty),
        .o_count(w_tx_count)
    );

    i2c_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst(rst),
        .i_push(w_rx_push), .i_data(rdata),
        .i_pop(w_rx_pop), .i_flush(1'b0),
        .o_data(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty),
        .o_count(w_rx_count)
    );

`ifdef I2C_BRIDGE_IRQ_EN
    logic [2:0] r_irq_en;
    logic       r_irq;

    // IRQ_EN register and registered interrupt from the sticky status bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_en <= 3'd0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_off == REG_IRQ_EN)) r_irq_en <= pwdata[3:1];
            r_irq <= |({r_rx_ovf, r_done, r_nack} & r_irq_en);
        end
    end

    assign irq = r_irq;
`endif

    // APB read mux and error response, valid only in the access phase.
    always_comb begin
        prdata  = 32'd0;
        pslverr = 1'b0;
        if (w_access) begin
            case (w_off)
                REG_CTRL:   pslverr = w_start_req & ~w_start_ok;
                REG_TXDATA: pslverr = pwrite & w_tx_full;
                REG_RXDATA: begin
                    if (!pwrite && w_rx_empty) begin
                        pslverr = 1'b1;
                    end else if (!pwrite) begin
                        prdata = {24'd0, w_rx_head};
                    end else begin
                        prdata = 32'd0;
                    end
                end
                REG_STATUS: begin
                    if (!pwrite) prdata = {24'd0, w_status};
                    else         prdata = 32'd0;
                end
`ifdef I2C_BRIDGE_IRQ_EN
                REG_IRQ_EN: begin
                    if (!pwrite) prdata = {28'd0, r_irq_en, 1'b0};
                    else         prdata = 32'd0;
                end
`endif
                default:    pslverr = 1'b1;
            endcase
        end else begin
            prdata  = 32'd0;
            pslverr = 1'b0;
        end
    end

    // Bridge FSM next state, command outputs and FIFO/flag strobes.
    always_comb begin
        w_next_state     = r_state;
        w_next_dv        = r_dv;
        w_next_write     = r_write;
        w_next_addr      = r_addr;
        w_next_rd_remain = r_rd_remain;
        w_next_guard_cnt = r_guard_cnt;
        w_tx_pop         = 1'b0;
        w_tx_flush       = 1'b0;
        w_rx_push        = 1'b0;
        w_set_nack       = 1'b0;
        w_set_done       = 1'b0;
        w_set_ovf        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_next_state     = pwdata[1] ? S_WR_RUN : S_RD_RUN;
                    w_next_dv        = 1'b1;
                    w_next_write     = pwdata[1];
                    w_next_addr      = pwdata[14:8];
                    w_next_rd_remain = eff_rd_len(pwdata[23:16]);
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_WR_RUN: begin
                if (w_ready_rise && i2c_error) begin
                    w_set_nack       = 1'b1;
                    w_tx_flush       = 1'b1;
                    w_next_dv        = 1'b0;
                    w_next_guard_cnt = '0;
                    w_next_state     = S_GUARD;
                end else if (w_ready_rise) begin
                    w_tx_pop = 1'b1;
                    if ((w_tx_count == CW'(1)) && !w_tx_push) begin
                        w_next_dv        = 1'b0;
                        w_next_guard_cnt = '0;
                        w_next_state     = S_GUARD;
                    end else begin
                        w_next_state = S_WR_RUN;
                    end
                end else begin
                    w_next_state = S_WR_RUN;
                end
            end
            S_RD_RUN: begin
                if (w_ready_rise && i2c_error) begin
                    w_set_nack       = 1'b1;
                    w_tx_flush       = 1'b1;
                    w_next_dv        = 1'b0;
                    w_next_guard_cnt = '0;
                    w_next_state     = S_GUARD;
                end else if (w_dval_rise) begin
                    w_rx_push        = 1'b1;
                    w_set_ovf        = w_rx_full & ~w_rx_pop;
                    w_next_rd_remain = r_rd_remain - 8'd1;
                    if (r_rd_remain == 8'd1) begin
                        w_next_dv        = 1'b0;
                        w_next_guard_cnt = '0;
                        w_next_state     = S_GUARD;
                    end else begin
                        w_next_state = S_RD_RUN;
                    end
                end else begin
                    w_next_state = S_RD_RUN;
                end
            end
            S_GUARD: begin
                if (r_guard_cnt == GUARD_LAST) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_guard_cnt = r_guard_cnt + GUARD_ONE;
                end
            end
            S_DONE: begin
                w_set_done   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_dv    = 1'b0;
            end
        endcase
    end

    // State, command and sticky status registers; reset aborts with no guard.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_dv        <= 1'b0;
            r_write     <= 1'b0;
            r_addr      <= 7'd0;
            r_rd_remain <= 8'd0;
            r_guard_cnt <= '0;
            r_ready_d   <= 1'b0;
            r_dval_d    <= 1'b0;
            r_nack      <= 1'b0;
            r_done      <= 1'b0;
            r_rx_ovf    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_dv        <= w_next_dv;
            r_write     <= w_next_write;
            r_addr      <= w_next_addr;
            r_rd_remain <= w_next_rd_remain;
            r_guard_cnt <= w_next_guard_cnt;
            r_ready_d   <= i2c_ready;
            r_dval_d    <= i2c_data_valid;
            r_nack      <= w_set_nack | (r_nack   & ~(w_stat_wr & pwdata[STAT_NACK]));
            r_done      <= w_set_done | (r_done   & ~(w_stat_wr & pwdata[STAT_DONE]));
            r_rx_ovf    <= w_set_ovf  | (r_rx_ovf & ~(w_stat_wr & pwdata[STAT_RX_OVF]));
        end
    end

endmodule
